// File: rtl/fmap_raster_tx.sv
// fmap_raster_tx: column-parallel strip buffer re-emitted as a raster pixel stream
// Define FMAP_TX_SAT_EN for saturating IN_W->OUT_W conversion; default is truncation.
module fmap_raster_tx #(
  parameter int ROWS   = 6,
  parameter int WIDTH  = 12,
  parameter int STRIPS = 2,
  parameter int IN_W   = 16,
  parameter int OUT_W  = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 col_valid_i,
  output logic                 col_ready_o,
  input  logic [ROWS*IN_W-1:0] col_data_i,
  input  logic                 out_ready_i,
  output logic                 valid_o,
  output logic                 wr_en_o,
  output logic [OUT_W-1:0]     data_o,
  output logic                 frame_done_o
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW = (STRIPS > 1) ? $clog2(STRIPS) : 1;
  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;
`ifdef FMAP_TX_SAT_EN
  localparam logic signed [IN_W-1:0] SAT_HI = IN_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] SAT_LO = ~SAT_HI;
  function automatic logic [OUT_W-1:0] conv(input logic signed [IN_W-1:0] x);
    return (x > SAT_HI) ? OUT_W'(SAT_HI) : (x < SAT_LO) ? OUT_W'(SAT_LO) : x[OUT_W-1:0];
  endfunction
`else
  function automatic logic [OUT_W-1:0] conv(input logic signed [IN_W-1:0] x);
    return x[OUT_W-1:0];
  endfunction
`endif
  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    col_cnt_q, col_cnt_d, pix_cnt_q, pix_cnt_d;
  logic [RW-1:0]    row_cnt_q, row_cnt_d;
  logic [SW-1:0]    strip_cnt_q, strip_cnt_d;
  logic             frame_done_q, frame_done_d;
  logic [OUT_W-1:0] mem_q [ROWS][WIDTH];
  logic             beat, xfer, last_col, last_pix, last_row, last_strip;
  assign col_ready_o  = (state_q == FILL);
  assign valid_o      = (state_q == DRAIN);
  assign wr_en_o      = valid_o;
  assign data_o       = valid_o ? mem_q[row_cnt_q][pix_cnt_q] : '0;
  assign frame_done_o = frame_done_q;
  assign beat         = col_ready_o & col_valid_i & ~clear_i;
  assign xfer         = valid_o & out_ready_i;
  assign last_col     = (col_cnt_q == CW'(WIDTH - 1));
  assign last_pix     = (pix_cnt_q == CW'(WIDTH - 1));
  assign last_row     = (row_cnt_q == RW'(ROWS - 1));
  assign last_strip   = (strip_cnt_q == SW'(STRIPS - 1));
  always_comb begin
    state_d      = state_q;
    col_cnt_d    = col_cnt_q;
    pix_cnt_d    = pix_cnt_q;
    row_cnt_d    = row_cnt_q;
    strip_cnt_d  = strip_cnt_q;
    frame_done_d = 1'b0;
    if (beat) begin
      col_cnt_d = last_col ? '0 : col_cnt_q + 1'b1;
      state_d   = last_col ? DRAIN : FILL;
    end
    if (xfer) begin
      pix_cnt_d = last_pix ? '0 : pix_cnt_q + 1'b1;
      row_cnt_d = last_pix ? (last_row ? '0 : row_cnt_q + 1'b1) : row_cnt_q;
      if (last_pix && last_row) begin
        state_d      = FILL;
        strip_cnt_d  = last_strip ? '0 : strip_cnt_q + 1'b1;
        frame_done_d = last_strip;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q      <= FILL;
      col_cnt_q    <= '0;
      pix_cnt_q    <= '0;
      row_cnt_q    <= '0;
      strip_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_cnt_q    <= col_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      row_cnt_q    <= row_cnt_d;
      strip_cnt_q  <= strip_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end
  // strip memory is data-only, so it carries no reset
  always_ff @(posedge clk_i) begin
    if (beat)
      for (int r = 0; r < ROWS; r++)
        mem_q[r][col_cnt_q] <= conv(col_data_i[r*IN_W +: IN_W]);
  end
endmodule

// File: tb/tb_fmap_raster_tx.sv
// tb_fmap_raster_tx: randomized stimulus against a queue-based raster model of fmap_raster_tx
module tb_fmap_raster_tx;
  localparam int ROWS = 6, WIDTH = 12, STRIPS = 2, IN_W = 16, OUT_W = 12;
  localparam int STRIP_PIX = ROWS * WIDTH;
  localparam int FRAME_PIX = STRIP_PIX * STRIPS;
  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 clear_i = 1'b0;
  logic                 col_valid_i = 1'b0;
  logic                 col_ready_o;
  logic [ROWS*IN_W-1:0] col_data_i = '0;
  logic                 out_ready_i = 1'b1;
  logic                 valid_o, wr_en_o, frame_done_o;
  logic [OUT_W-1:0]     data_o;
  int errors = 0, checks = 0;
  int exp_q[$];
  int pix_seen = 0, frame_pix = 0, done_cnt = 0, or_mode = 0;
  bit done_exp = 0, end_prev = 0, chk_clear = 0, bp_used = 0;
  logic [IN_W-1:0] cur [ROWS][WIDTH];
  fmap_raster_tx #(.ROWS(ROWS), .WIDTH(WIDTH), .STRIPS(STRIPS), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .col_valid_i(col_valid_i),
    .col_ready_o(col_ready_o), .col_data_i(col_data_i), .out_ready_i(out_ready_i),
    .valid_o(valid_o), .wr_en_o(wr_en_o), .data_o(data_o), .frame_done_o(frame_done_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int conv(input logic [IN_W-1:0] raw);
    int v = int'($signed(raw));
`ifdef FMAP_TX_SAT_EN
    return (v > 2047) ? 2047 : (v < -2048) ? -2048 : v;
`else
    int m = v & 32'hFFF;
    return (m >= 2048) ? m - 4096 : m;
`endif
  endfunction
  always @(negedge clk_i) begin
    if (!rst_i) begin
      check("wr_en_eq_valid", wr_en_o, valid_o);
      if (chk_clear) begin
        check("clear_valid", valid_o, 0);
        check("clear_ready", col_ready_o, 1);
        chk_clear = 0;
      end
      if (end_prev) begin
        check("ready_after_strip", col_ready_o, 1);
        end_prev = 0;
      end
      check("frame_done", frame_done_o, done_exp);
      if (frame_done_o) done_cnt++;
      done_exp = 0;
      if (!valid_o) check("idle_data", data_o, 0);
      if (clear_i) begin
        exp_q.delete();
        pix_seen = 0;
        frame_pix = 0;
        chk_clear = 1;
      end else if (valid_o) begin
        if (exp_q.size() == 0) check("extra_pixel", valid_o, 0);
        else begin
          check(out_ready_i ? "pixel" : "hold", int'($signed(data_o)), exp_q[0]);
          if (out_ready_i) begin
            void'(exp_q.pop_front());
            pix_seen++;
            frame_pix++;
            if (pix_seen == STRIP_PIX) begin pix_seen = 0; end_prev = 1; end
            if (frame_pix == FRAME_PIX) begin frame_pix = 0; done_exp = 1; end
          end
        end
      end
    end
  end
  // downstream ready: always on, random, or a single 3-cycle stall at pixel 20
  initial forever begin
    @(posedge clk_i); #1;
    if (or_mode == 1) out_ready_i = ($urandom_range(9) < 7);
    else if (or_mode == 2 && pix_seen == 20 && !bp_used) begin
      bp_used = 1;
      out_ready_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1 out_ready_i = 1'b1;
    end else out_ready_i = 1'b1;
  end
  task automatic send_strip(input bit gaps);
    int c = 0, budget = 0;
    bit acc;
    while (c < WIDTH && budget < 1000) begin
      col_valid_i = gaps ? ($urandom_range(3) != 0) : 1'b1;
      for (int r = 0; r < ROWS; r++) col_data_i[r*IN_W +: IN_W] = cur[r][c];
      @(negedge clk_i);
      acc = col_valid_i && col_ready_o && !clear_i;
      if (acc && c == WIDTH - 1)
        for (int r = 0; r < ROWS; r++)
          for (int k = 0; k < WIDTH; k++) exp_q.push_back(conv(cur[r][k]));
      @(posedge clk_i); #1;
      if (acc) c++;
      budget++;
    end
    col_valid_i = 1'b0;
    if (c < WIDTH) check("fill_timeout", c, WIDTH);
  endtask
  task automatic fill_random();
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < WIDTH; k++) cur[r][k] = IN_W'($urandom);
  endtask
  task automatic wait_drain();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk_i);
    check("drain_timeout", exp_q.size(), 0);
    repeat (3) @(posedge clk_i);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_valid", valid_o, 0);
    check("rst_wr_en", wr_en_o, 0);
    check("rst_data", data_o, 0);
    check("rst_ready", col_ready_o, 1);
    check("rst_done", frame_done_o, 0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < WIDTH; k++) cur[r][k] = IN_W'(r * 16 + k);
    send_strip(0);
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < WIDTH; k++) cur[r][k] = IN_W'(r * 16 + k + 200);
    send_strip(0);
    wait_drain();
    or_mode = 2;
    fill_random();
    cur[0][0] = 16'sh1000;
    cur[0][1] = IN_W'(-3000);
    send_strip(0);
    fill_random();
    send_strip(0);
    wait_drain();
    or_mode = 0;
    check("bp_applied", int'(bp_used), 1);
    fill_random();
    send_strip(0);
    fill_random();
    send_strip(0);
    for (int i = 0; i < 500 && pix_seen != 30; i++) begin @(posedge clk_i); #1; end
    check("clear_reach_px30", pix_seen, 30);
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    for (int s = 0; s < STRIPS; s++) begin fill_random(); send_strip(0); end
    wait_drain();
    or_mode = 1;
    for (int f = 0; f < 3; f++)
      for (int s = 0; s < STRIPS; s++) begin fill_random(); send_strip(1); end
    wait_drain();
    or_mode = 0;
    repeat (4) @(negedge clk_i);
    check("frame_count", done_cnt, 6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
